branch_pred_ctrl: RTL and testbench

- Sequences the 16-entry 2-bit branch predictor array for the pipelined core.
- Holds IF-stage predictions in an in-order in-flight queue and compares each against its MEM-stage resolution.
- Issues the predictor update write and, on a mispredict, generates the pipeline flush and redirect PC.
- Maintains branch and mispredict counters.

---
 rtl/branch_pred_pkg.sv | 26 ++
 rtl/branch_pred_if.sv | 47 ++++
 rtl/pred_fifo.sv | 59 +++++
 rtl/branch_pred_ctrl.sv | 163 ++++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pred_pkg.sv
// Shared types for the branch predictor controller.
//   pred_entry_t : one in-flight prediction {idx, pred_taken, pred_target}
//   ctrl_state_t : controller state (RUN / FLUSH)
//   pc_to_idx    : predictor index extraction, idx = pc[IDX_W:1]
package branch_pred_pkg;

  localparam int BP_IDX_W  = 4;
  localparam int BP_ADDR_W = 16;

  typedef struct packed {
    logic [BP_IDX_W-1:0]  idx;
    logic                 pred_taken;
    logic [BP_ADDR_W-1:0] pred_target;
  } pred_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  // Instructions are halfword aligned, so bit 0 carries no information.
  function automatic logic [BP_IDX_W-1:0] pc_to_idx(input logic [BP_ADDR_W-1:0] pc);
    return pc[BP_IDX_W:1];
  endfunction

endpackage

// File: rtl/branch_pred_if.sv
// Pipeline <-> branch predictor controller bus.
//   IF side    : if_br_valid, if_pc, if_pred_taken, if_pred_target -> ctrl
//                pred_index_a, if_stall                             <- ctrl
//   MEM side   : mem_br_valid, mem_br_en, mem_target, mem_fallthrough -> ctrl
//   Update     : pred_write, pred_br_en, pred_index_b               <- ctrl
//   Redirect   : flush, redirect_valid, redirect_pc                 <- ctrl
// master = pipeline side, slave = controller side.
interface branch_pred_if;
  import branch_pred_pkg::*;

  logic                 if_br_valid;
  logic [BP_ADDR_W-1:0] if_pc;
  logic                 if_pred_taken;
  logic [BP_ADDR_W-1:0] if_pred_target;
  logic [BP_IDX_W-1:0]  pred_index_a;
  logic                 if_stall;

  logic                 mem_br_valid;
  logic                 mem_br_en;
  logic [BP_ADDR_W-1:0] mem_target;
  logic [BP_ADDR_W-1:0] mem_fallthrough;

  logic                 pred_write;
  logic                 pred_br_en;
  logic [BP_IDX_W-1:0]  pred_index_b;

  logic                 flush;
  logic                 redirect_valid;
  logic [BP_ADDR_W-1:0] redirect_pc;

  modport master (
    output if_br_valid, if_pc, if_pred_taken, if_pred_target,
    output mem_br_valid, mem_br_en, mem_target, mem_fallthrough,
    input  pred_index_a, if_stall,
    input  pred_write, pred_br_en, pred_index_b,
    input  flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  if_br_valid, if_pc, if_pred_taken, if_pred_target,
    input  mem_br_valid, mem_br_en, mem_target, mem_fallthrough,
    output pred_index_a, if_stall,
    output pred_write, pred_br_en, pred_index_b,
    output flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/pred_fifo.sv
// In-order queue of in-flight predictions.
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous flush of all entries (wins over push/pop)
//   push/din : enqueue (ignored when full unless popping the same cycle)
//   pop/dout : dequeue; dout shows the head combinationally
//   count, full, empty : occupancy
module pred_fifo
  import branch_pred_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  pred_entry_t              din,
  input  logic                     pop,
  output pred_entry_t              dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  pred_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor controller for the pipelined core.
// Queues IF-stage predictions, checks each against its MEM-stage resolution,
// writes the 2-bit predictor back, and on a mispredict raises flush and a
// one-cycle redirect to the corrected PC.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : IF push, MEM resolve, predictor update, redirect
//   q_count           : predictions in flight
//   stat_branches     : resolved branches (saturating)
//   stat_mispredicts  : mispredicted branches (saturating)
//   err_overflow      : sticky, push dropped on a full queue
//   err_underflow     : sticky, resolve with an empty queue
module branch_pred_ctrl
  import branch_pred_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int IDX_W        = BP_IDX_W,
  parameter int ADDR_W       = BP_ADDR_W,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_pred_if.slave           bus,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [CNT_W-1:0]       stat_branches,
  output logic [CNT_W-1:0]       stat_mispredicts,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_state_t       state, state_nxt;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_nxt;
  logic              flush_o;

  pred_entry_t       push_ent;
  pred_entry_t       head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_run;
  logic              pop;
  logic              push;
  logic              mispredict;

  logic              pred_write_p1;
  logic              pred_br_en_p1;
  logic [IDX_W-1:0]  pred_idx_p1;
  logic              redirect_vld_p1;
  logic [ADDR_W-1:0] redirect_pc_p1;

  assign in_run = (state == RUN);
  assign pop    = bus.mem_br_valid && in_run && !fifo_empty;

  // A pop in the same cycle frees the slot the push needs.
  assign bus.if_stall     = !in_run || (fifo_full && !pop);
  assign push             = bus.if_br_valid && !bus.if_stall;
  assign bus.pred_index_a = pc_to_idx(bus.if_pc);

  assign push_ent.idx         = pc_to_idx(bus.if_pc);
  assign push_ent.pred_taken  = bus.if_pred_taken;
  assign push_ent.pred_target = bus.if_pred_target;

  // Target only matters when the branch was actually taken.
  assign mispredict = pop &&
                      ((head.pred_taken != bus.mem_br_en) ||
                       (bus.mem_br_en && (head.pred_target != bus.mem_target)));

  // Clearing on a mispredict also discards a same-cycle push (younger path).
  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (mispredict),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head),
    .count (q_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    flush_o       = 1'b0;
    case (state)
      RUN: begin
        if (mispredict) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (flush_cnt == FC_W'(FLUSH_CYCLES - 1)) begin
          state_nxt     = RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = '0;
      end
    endcase
  end

  // ---- stage p1: registered resolve results ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_write_p1    <= 1'b0;
      pred_br_en_p1    <= 1'b0;
      pred_idx_p1      <= '0;
      redirect_vld_p1  <= 1'b0;
      redirect_pc_p1   <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      err_overflow     <= 1'b0;
      err_underflow    <= 1'b0;
    end else begin
      pred_write_p1   <= pop;
      redirect_vld_p1 <= mispredict;
      if (pop) begin
        pred_br_en_p1 <= bus.mem_br_en;
        pred_idx_p1   <= head.idx;
        stat_branches <= sat_inc(stat_branches);
      end
      if (mispredict) begin
        stat_mispredicts <= sat_inc(stat_mispredicts);
        redirect_pc_p1   <= bus.mem_br_en ? bus.mem_target : bus.mem_fallthrough;
      end
      if (bus.mem_br_valid && in_run && fifo_empty)
        err_underflow <= 1'b1;
      // Only a genuinely full queue counts; FLUSH stalls are expected.
      if (bus.if_br_valid && in_run && fifo_full && !pop)
        err_overflow <= 1'b1;
    end
  end

  assign bus.pred_write     = pred_write_p1;
  assign bus.pred_br_en     = pred_br_en_p1;
  assign bus.pred_index_b   = pred_idx_p1;
  assign bus.redirect_valid = redirect_vld_p1;
  assign bus.redirect_pc    = redirect_pc_p1;
  assign bus.flush          = flush_o;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
module tb_branch_pred_ctrl;
  import branch_pred_pkg::*;

  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(DEPTH):0] q_count;
  logic [CNT_W-1:0] stat_branches, stat_mispredicts;
  logic err_overflow, err_underflow;

  branch_pred_if bif();

  branch_pred_ctrl #(
    .DEPTH(DEPTH), .IDX_W(4), .ADDR_W(16), .CNT_W(CNT_W), .FLUSH_CYCLES(FC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bif.slave),
    .q_count          (q_count),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of outstanding predictions plus
  // the values the outputs are expected to show after each edge.
  typedef struct {
    int unsigned idx;
    bit          tk;
    int unsigned tgt;
  } ment_t;

  ment_t       mq[$];
  int          flush_left;
  bit          e_pw, e_bren, e_rv, e_ov, e_un;
  int unsigned e_idxb, e_rpc, e_br, e_mis;

  task automatic model_reset();
    mq.delete();
    flush_left = 0;
    e_pw = 0; e_bren = 0; e_rv = 0; e_ov = 0; e_un = 0;
    e_idxb = 0; e_rpc = 0; e_br = 0; e_mis = 0;
  endtask

  // One clock: drive inputs, check combinational outputs, advance the
  // model by the rules, then check every registered output after the edge.
  task automatic step(input bit r, input bit iv, input logic [15:0] ipc,
                      input bit itk, input logic [15:0] itgt,
                      input bit mv, input bit men, input logic [15:0] mt,
                      input logic [15:0] mf);
    bit flushing, pop, stall, mis;
    ment_t h, n;
    rst                 = r;
    bif.if_br_valid     = iv;
    bif.if_pc           = ipc;
    bif.if_pred_taken   = itk;
    bif.if_pred_target  = itgt;
    bif.mem_br_valid    = mv;
    bif.mem_br_en       = men;
    bif.mem_target      = mt;
    bif.mem_fallthrough = mf;
    #3;
    flushing = (flush_left > 0);
    pop      = mv && !flushing && (mq.size() > 0);
    stall    = flushing || (mq.size() == DEPTH && !pop);
    check_eq("if_stall", 32'(bif.if_stall), 32'(stall));
    check_eq("pred_index_a", 32'(bif.pred_index_a), (32'(ipc) / 2) % 16);
    if (r) begin
      model_reset();
    end else begin
      if (mv && !flushing && mq.size() == 0) e_un = 1;
      if (iv && !flushing && stall) e_ov = 1;
      e_pw = pop;
      e_rv = 0;
      mis  = 0;
      if (pop) begin
        h      = mq.pop_front();
        e_idxb = h.idx;
        e_bren = men;
        mis    = (h.tk != men) || (men && h.tgt != 32'(mt));
        if (e_br < 65535) e_br++;
        if (mis && e_mis < 65535) e_mis++;
      end
      if (iv && !stall) begin
        n.idx = (32'(ipc) / 2) % 16;
        n.tk  = itk;
        n.tgt = 32'(itgt);
        mq.push_back(n);
      end
      if (mis) begin
        mq.delete();
        flush_left = FC;
        e_rv  = 1;
        e_rpc = men ? 32'(mt) : 32'(mf);
      end else if (flushing) begin
        flush_left--;
      end
    end
    @(posedge clk);
    #1;
    check_eq("pred_write", 32'(bif.pred_write), 32'(e_pw));
    check_eq("pred_br_en", 32'(bif.pred_br_en), 32'(e_bren));
    check_eq("pred_index_b", 32'(bif.pred_index_b), e_idxb);
    check_eq("redirect_valid", 32'(bif.redirect_valid), 32'(e_rv));
    check_eq("redirect_pc", 32'(bif.redirect_pc), e_rpc);
    check_eq("flush", 32'(bif.flush), 32'(flush_left > 0));
    check_eq("q_count", 32'(q_count), 32'(mq.size()));
    check_eq("stat_branches", 32'(stat_branches), e_br);
    check_eq("stat_mispredicts", 32'(stat_mispredicts), e_mis);
    check_eq("err_overflow", 32'(err_overflow), 32'(e_ov));
    check_eq("err_underflow", 32'(err_underflow), 32'(e_un));
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic push(input logic [15:0] pc, input bit tk, input logic [15:0] tgt);
    step(0, 1, pc, tk, tgt, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic resolve(input bit en, input logic [15:0] tgt, input logic [15:0] fall);
    step(0, 0, 16'h0, 0, 16'h0, 1, en, tgt, fall);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] tgts [4];
    model_reset();
    rst = 1'b1;
    bif.if_br_valid = 0; bif.if_pc = 0; bif.if_pred_taken = 0; bif.if_pred_target = 0;
    bif.mem_br_valid = 0; bif.mem_br_en = 0; bif.mem_target = 0; bif.mem_fallthrough = 0;
    @(posedge clk); #1;
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    idle();
    check_eq("tp_reset_qcount", 32'(q_count), 0);
    check_eq("tp_reset_stall", 32'(bif.if_stall), 0);

    // Correct not-taken prediction
    push(16'h0010, 0, 16'h0000);
    idle();
    resolve(0, 16'h0000, 16'h0012);
    check_eq("tp_nt_write", 32'(bif.pred_write), 1);
    check_eq("tp_nt_idx", 32'(bif.pred_index_b), 32'h8);
    check_eq("tp_nt_flush", 32'(bif.flush), 0);
    check_eq("tp_nt_branches", 32'(stat_branches), 1);

    // Direction mispredict
    push(16'h0024, 0, 16'h0000);
    resolve(1, 16'h0100, 16'h0026);
    check_eq("tp_dir_rv", 32'(bif.redirect_valid), 1);
    check_eq("tp_dir_rpc", 32'(bif.redirect_pc), 32'h0100);
    check_eq("tp_dir_mis", 32'(stat_mispredicts), 1);
    idle();
    check_eq("tp_dir_rv_off", 32'(bif.redirect_valid), 0);
    check_eq("tp_dir_flush2", 32'(bif.flush), 1);
    idle();
    check_eq("tp_dir_flush_end", 32'(bif.flush), 0);

    // Fill the queue, push+pop when full, overflow
    for (int i = 0; i < 4; i++) push(16'(16'h0030 + 2 * i), 0, 16'h0);
    check_eq("tp_full_stall", 32'(bif.if_stall), 1);
    step(0, 1, 16'h0040, 0, 16'h0, 1, 0, 16'h0, 16'h0);
    check_eq("tp_full_pushpop", 32'(q_count), 4);
    push(16'h0050, 0, 16'h0);
    check_eq("tp_overflow", 32'(err_overflow), 1);
    for (int i = 0; i < 4; i++) resolve(0, 16'h0, 16'h0);

    // Target mispredict
    push(16'h0060, 1, 16'h0040);
    resolve(1, 16'h0044, 16'h0062);
    check_eq("tp_tgt_rpc", 32'(bif.redirect_pc), 32'h0044);
    check_eq("tp_tgt_bren", 32'(bif.pred_br_en), 1);
    idle();
    idle();

    // Resolve on empty queue
    resolve(1, 16'h0, 16'h0);
    check_eq("tp_underflow", 32'(err_underflow), 1);
    check_eq("tp_underflow_nowrite", 32'(bif.pred_write), 0);

    // Reset in the middle of a flush
    push(16'h0070, 0, 16'h0);
    resolve(1, 16'h0200, 16'h0072);
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    check_eq("tp_rst_flush", 32'(bif.flush), 0);
    check_eq("tp_rst_stall", 32'(bif.if_stall), 0);
    check_eq("tp_rst_branches", 32'(stat_branches), 0);

    // Randomized traffic
    tgts[0] = 16'h0040; tgts[1] = 16'h0044; tgts[2] = 16'h0100; tgts[3] = 16'h0200;
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 249) == 0),
           ($urandom_range(0, 99) < 55),
           16'($urandom() & 32'hFFFE),
           1'($urandom()),
           tgts[$urandom_range(0, 3)],
           ($urandom_range(0, 99) < 45),
           1'($urandom()),
           tgts[$urandom_range(0, 3)],
           16'($urandom() & 32'hFFFE));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
